// File: rtl/dma_arbiter.sv
// Two-master arbiter in front of the core DMA port: burst locking, fixed or
// round-robin priority, per-master masking, read-response routing and stall counters.
module dma_arbiter #(
   parameter logic [14:0] BASE_ADDR = 15'h0080,
   parameter int          DEC_WD    = 3
) (
   input  logic        mclk,
   input  logic        puc_rst,
   input  logic [13:0] per_addr,
   input  logic [15:0] per_din,
   input  logic        per_en,
   input  logic [1:0]  per_we,
   output logic [15:0] per_dout,
   input  logic [14:0] m0_addr,
   input  logic [14:0] m1_addr,
   input  logic [15:0] m0_din,
   input  logic [15:0] m1_din,
   input  logic        m0_en,
   input  logic        m1_en,
   input  logic [1:0]  m0_we,
   input  logic [1:0]  m1_we,
   input  logic        m0_priority,
   input  logic        m1_priority,
   output logic [15:0] m0_dout,
   output logic [15:0] m1_dout,
   output logic        m0_ready,
   output logic        m1_ready,
   output logic        m0_resp,
   output logic        m1_resp,
   output logic [14:0] dma_addr,
   output logic [15:0] dma_din,
   output logic        dma_en,
   output logic [1:0]  dma_we,
   output logic        dma_priority,
   input  logic [15:0] dma_dout,
   input  logic        dma_ready,
   input  logic        dma_resp
);

   typedef enum logic [1:0] {IDLE = 2'd0, LOCK0 = 2'd1, LOCK1 = 2'd2} state_t;

   state_t      state, state_nxt;
   logic        last_owner;
   logic        rr_en, m0_mask, m1_mask;
   logic [15:0] stall0, stall1;
   logic        rsp_owner, rsp_pending;
   logic        req0, req1, gnt_valid, gnt_id, accept_rd;
   logic        reg_sel, reg_wr, reg_rd;
   logic [1:0]  reg_idx;
   logic [15:0] rd_data;
   logic        unused_din;

   assign unused_din = ^per_din[15:3];

   assign reg_sel = per_en & (per_addr[13:DEC_WD-1] == BASE_ADDR[14:DEC_WD]);
   assign reg_idx = per_addr[DEC_WD-2:0];
   assign reg_wr  = reg_sel & (|per_we);
   assign reg_rd  = reg_sel & ~(|per_we);

   always_ff @(posedge mclk or posedge puc_rst) begin
      if (puc_rst)                        {m1_mask, m0_mask, rr_en} <= 3'b000;
      else if (reg_wr && reg_idx == 2'd0) {m1_mask, m0_mask, rr_en} <= per_din[2:0];
   end

   // A register write clears the counter even when an increment is due.
   always_ff @(posedge mclk or posedge puc_rst) begin
      if (puc_rst)                                        stall0 <= 16'h0000;
      else if (reg_wr && reg_idx == 2'd1)                 stall0 <= 16'h0000;
      else if (m0_en && !m0_ready && stall0 != 16'hFFFF) stall0 <= stall0 + 16'd1;
   end

   always_ff @(posedge mclk or posedge puc_rst) begin
      if (puc_rst)                                        stall1 <= 16'h0000;
      else if (reg_wr && reg_idx == 2'd2)                 stall1 <= 16'h0000;
      else if (m1_en && !m1_ready && stall1 != 16'hFFFF) stall1 <= stall1 + 16'd1;
   end

   // Requests are gated by reset so nothing reaches the core while it is held.
   assign req0 = m0_en & ~m0_mask & ~puc_rst;
   assign req1 = m1_en & ~m1_mask & ~puc_rst;

   always_comb begin
      gnt_valid = 1'b0;
      gnt_id    = 1'b0;
      if (state == LOCK0 && req0) begin
         gnt_valid = 1'b1;
         gnt_id    = 1'b0;
      end else if (state == LOCK1 && req1) begin
         gnt_valid = 1'b1;
         gnt_id    = 1'b1;
      end else if (req0 && req1) begin
         gnt_valid = 1'b1;
         gnt_id    = rr_en ? ~last_owner : 1'b0;
      end else if (req0) begin
         gnt_valid = 1'b1;
         gnt_id    = 1'b0;
      end else if (req1) begin
         gnt_valid = 1'b1;
         gnt_id    = 1'b1;
      end
      state_nxt = IDLE;
      if (gnt_valid) state_nxt = gnt_id ? LOCK1 : LOCK0;
   end

   always_ff @(posedge mclk or posedge puc_rst) begin
      if (puc_rst) begin
         state      <= IDLE;
         last_owner <= 1'b1;
      end else begin
         state <= state_nxt;
         if (gnt_valid) last_owner <= gnt_id;
      end
   end

   assign dma_en       = gnt_valid;
   assign dma_addr     = !gnt_valid ? 15'h0000 : (gnt_id ? m1_addr : m0_addr);
   assign dma_din      = !gnt_valid ? 16'h0000 : (gnt_id ? m1_din : m0_din);
   assign dma_we       = !gnt_valid ? 2'b00    : (gnt_id ? m1_we : m0_we);
   assign dma_priority = gnt_valid & (gnt_id ? m1_priority : m0_priority);
   assign m0_ready     = gnt_valid & ~gnt_id & dma_ready;
   assign m1_ready     = gnt_valid & gnt_id & dma_ready;

   // The owner is captured at acceptance, so a grant switch does not misroute data.
   assign accept_rd = gnt_valid & dma_ready & (dma_we == 2'b00);

   always_ff @(posedge mclk or posedge puc_rst) begin
      if (puc_rst) begin
         rsp_pending <= 1'b0;
         rsp_owner   <= 1'b0;
      end else begin
         rsp_pending <= accept_rd;
         if (accept_rd) rsp_owner <= gnt_id;
      end
   end

   assign m0_dout = (rsp_pending & ~rsp_owner) ? dma_dout : 16'h0000;
   assign m1_dout = (rsp_pending & rsp_owner)  ? dma_dout : 16'h0000;
   assign m0_resp = rsp_pending & ~rsp_owner & dma_resp;
   assign m1_resp = rsp_pending & rsp_owner & dma_resp;

   always_comb begin
      rd_data = 16'h0000;
      case (reg_idx)
         2'd0: rd_data = {13'h0000, m1_mask, m0_mask, rr_en};
         2'd1: rd_data = stall0;
         2'd2: rd_data = stall1;
         2'd3: rd_data = {12'h000, rsp_pending, rsp_owner, (state != IDLE), gnt_id};
         default: rd_data = 16'h0000;
      endcase
   end

   assign per_dout = (reg_rd & ~puc_rst) ? rd_data : 16'h0000;

endmodule

// File: tb/tb_dma_arbiter.sv
// Self-checking bench for dma_arbiter: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a behavioural model.
module tb_dma_arbiter;

   logic        mclk = 1'b0;
   logic        puc_rst;
   logic [13:0] per_addr;
   logic [15:0] per_din;
   logic        per_en;
   logic [1:0]  per_we;
   logic [15:0] per_dout;
   logic [14:0] m0_addr, m1_addr;
   logic [15:0] m0_din, m1_din;
   logic        m0_en, m1_en;
   logic [1:0]  m0_we, m1_we;
   logic        m0_priority, m1_priority;
   logic [15:0] m0_dout, m1_dout;
   logic        m0_ready, m1_ready, m0_resp, m1_resp;
   logic [14:0] dma_addr;
   logic [15:0] dma_din;
   logic        dma_en;
   logic [1:0]  dma_we;
   logic        dma_priority;
   logic [15:0] dma_dout;
   logic        dma_ready, dma_resp;

   localparam logic [13:0] REG_CTRL   = 14'h0040;
   localparam logic [13:0] REG_STALL0 = 14'h0041;
   localparam logic [13:0] REG_STALL1 = 14'h0042;
   localparam logic [13:0] REG_STATUS = 14'h0043;

   int n_tests = 0;
   int n_fail  = 0;

   // model state
   int          lock_m = -1;
   int          last_m = 1;
   logic [2:0]  ctrl_m = 3'b000;
   int          s0_m = 0;
   int          s1_m = 0;
   logic        pend_m = 1'b0;
   logic        rown_m = 1'b0;

   logic [14:0] exp_q[$];

   dma_arbiter dut (
      .mclk(mclk), .puc_rst(puc_rst),
      .per_addr(per_addr), .per_din(per_din), .per_en(per_en), .per_we(per_we), .per_dout(per_dout),
      .m0_addr(m0_addr), .m1_addr(m1_addr), .m0_din(m0_din), .m1_din(m1_din),
      .m0_en(m0_en), .m1_en(m1_en), .m0_we(m0_we), .m1_we(m1_we),
      .m0_priority(m0_priority), .m1_priority(m1_priority),
      .m0_dout(m0_dout), .m1_dout(m1_dout), .m0_ready(m0_ready), .m1_ready(m1_ready),
      .m0_resp(m0_resp), .m1_resp(m1_resp),
      .dma_addr(dma_addr), .dma_din(dma_din), .dma_en(dma_en), .dma_we(dma_we),
      .dma_priority(dma_priority), .dma_dout(dma_dout), .dma_ready(dma_ready), .dma_resp(dma_resp)
   );

   // clock / reset
   always #5 mclk = ~mclk;

   task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // driver tasks
   task automatic idle();
      per_addr = '0; per_din = '0; per_en = 1'b0; per_we = 2'b00;
      m0_addr = '0; m1_addr = '0; m0_din = '0; m1_din = '0;
      m0_en = 1'b0; m1_en = 1'b0; m0_we = 2'b00; m1_we = 2'b00;
      m0_priority = 1'b0; m1_priority = 1'b0;
      dma_dout = '0; dma_ready = 1'b0; dma_resp = 1'b0;
   endtask

   task automatic cyc();
      @(posedge mclk);
      #1;
   endtask

   task automatic per_write(input logic [13:0] a, input logic [15:0] d);
      per_en = 1'b1; per_we = 2'b11; per_addr = a; per_din = d;
   endtask

   task automatic per_read(input logic [13:0] a);
      per_en = 1'b1; per_we = 2'b00; per_addr = a; per_din = '0;
   endtask

   // scoreboard: evaluate the arbitration rules on the current inputs, compare, then advance
   always @(negedge mclk) begin
      int          g;
      logic        r0, r1, sel, wr, rd;
      logic [1:0]  off;
      logic [14:0] e_addr;
      logic [15:0] e_din, e_rd;
      logic [1:0]  e_we;
      logic        e_pri;
      if (puc_rst) begin
         chk("reset_outputs",
             96'({dma_en, m0_ready, m1_ready, m0_dout, m1_dout, m0_resp, m1_resp, per_dout}), 96'(0));
         lock_m = -1; last_m = 1; ctrl_m = 3'b000; s0_m = 0; s1_m = 0; pend_m = 1'b0; rown_m = 1'b0;
      end else begin
         r0 = m0_en && !ctrl_m[1];
         r1 = m1_en && !ctrl_m[2];
         if (lock_m == 0 && r0)      g = 0;
         else if (lock_m == 1 && r1) g = 1;
         else if (r0 && r1)          g = ctrl_m[0] ? 1 - last_m : 0;
         else if (r0)                g = 0;
         else if (r1)                g = 1;
         else                        g = -1;

         e_addr = (g == 0) ? m0_addr : (g == 1) ? m1_addr : 15'h0000;
         e_din  = (g == 0) ? m0_din  : (g == 1) ? m1_din  : 16'h0000;
         e_we   = (g == 0) ? m0_we   : (g == 1) ? m1_we   : 2'b00;
         e_pri  = (g == 0) ? m0_priority : (g == 1) ? m1_priority : 1'b0;

         sel = per_en && (per_addr[13:2] == 12'h010);
         off = per_addr[1:0];
         wr  = sel && (per_we != 2'b00);
         rd  = sel && (per_we == 2'b00);
         case (off)
            2'd0: e_rd = {13'h0, ctrl_m};
            2'd1: e_rd = 16'(s0_m);
            2'd2: e_rd = 16'(s1_m);
            default: e_rd = {12'h0, pend_m, rown_m, (lock_m >= 0), (g == 1)};
         endcase
         if (!rd) e_rd = 16'h0000;

         chk("cycle_outputs",
             96'({dma_en, dma_addr, dma_din, dma_we, dma_priority, m0_ready, m1_ready,
                  m0_dout, m1_dout, m0_resp, m1_resp, per_dout}),
             96'({(g >= 0), e_addr, e_din, e_we, e_pri, (g == 0) && dma_ready, (g == 1) && dma_ready,
                  (pend_m && !rown_m) ? dma_dout : 16'h0, (pend_m && rown_m) ? dma_dout : 16'h0,
                  pend_m && !rown_m && dma_resp, pend_m && rown_m && dma_resp, e_rd}));

         if (wr && off == 2'd1) s0_m = 0;
         else if (m0_en && !(g == 0 && dma_ready) && s0_m < 65535) s0_m++;
         if (wr && off == 2'd2) s1_m = 0;
         else if (m1_en && !(g == 1 && dma_ready) && s1_m < 65535) s1_m++;
         if (wr && off == 2'd0) ctrl_m = per_din[2:0];
         if (g >= 0 && dma_ready && e_we == 2'b00) begin
            pend_m = 1'b1;
            rown_m = (g == 1);
         end else begin
            pend_m = 1'b0;
         end
         if (g >= 0) last_m = g;
         lock_m = g;
      end
   end

   initial begin
      idle();
      puc_rst = 1'b1;
      repeat (3) @(posedge mclk);
      #2;
      chk("rst_dma_en", 96'(dma_en), 96'(0));
      chk("rst_per_dout", 96'(per_dout), 96'(0));

      // single read from m0, response routed one cycle later
      cyc(); puc_rst = 1'b0;
      m0_en = 1'b1; m0_addr = 15'(16'h0200 >> 1); m0_we = 2'b00; dma_ready = 1'b1;
      #1;
      chk("t1_dma_en", 96'(dma_en), 96'(1));
      chk("t1_dma_addr", 96'(dma_addr), 96'(15'h0100));
      cyc(); idle(); dma_dout = 16'hBEEF;
      #1;
      chk("t1_m0_dout", 96'(m0_dout), 96'(16'hBEEF));
      chk("t1_m1_dout", 96'(m1_dout), 96'(0));

      // fixed priority with burst lock; m1 stalls for five cycles
      cyc(); idle(); per_write(REG_STALL1, 16'h0000);
      for (int i = 0; i < 5; i++) begin
         cyc(); idle();
         m0_en = 1'b1; m1_en = 1'b1; m0_addr = 15'h0001; m1_addr = 15'h0002; dma_ready = 1'b1; m0_we = 2'b11;
         #1;
         chk("t2_m0_granted", 96'({dma_en, dma_addr}), 96'({1'b1, 15'h0001}));
         chk("t2_m1_ready", 96'(m1_ready), 96'(0));
      end
      cyc(); idle();
      m1_en = 1'b1; m1_addr = 15'h0002; dma_ready = 1'b1; m1_we = 2'b11; per_read(REG_STALL1);
      #1;
      chk("t2_m1_takes_over", 96'({dma_en, dma_addr, m1_ready}), 96'({1'b1, 15'h0002, 1'b1}));
      chk("t2_stall1", 96'(per_dout), 96'(5));

      // masking m0 mid-burst hands the grant to m1 after the write
      cyc(); idle(); m0_en = 1'b1; m0_addr = 15'h0011; dma_ready = 1'b1;
      cyc(); idle(); m0_en = 1'b1; m1_en = 1'b1; m0_addr = 15'h0011; m1_addr = 15'h0022; dma_ready = 1'b1;
      per_write(REG_CTRL, 16'h0002);
      #1;
      chk("t3_m0_still_owner", 96'(dma_addr), 96'(15'h0011));
      cyc(); idle(); m0_en = 1'b1; m1_en = 1'b1; m0_addr = 15'h0011; m1_addr = 15'h0022; dma_ready = 1'b1;
      per_read(REG_STATUS);
      #1;
      chk("t3_m1_granted", 96'({dma_addr, m1_ready, m0_ready}), 96'({15'h0022, 1'b1, 1'b0}));
      chk("t3_status_owner", 96'(per_dout[0]), 96'(1));
      cyc(); idle(); per_write(REG_CTRL, 16'h0000);

      // reset in the middle of a locked burst
      cyc(); idle(); m0_en = 1'b1; m0_addr = 15'h0033; dma_ready = 1'b1;
      cyc(); idle(); m0_en = 1'b1; m1_en = 1'b1; m0_addr = 15'h0033; m1_addr = 15'h0044; dma_ready = 1'b1;
      #2;
      puc_rst = 1'b1;
      #1;
      chk("t4_rst_dma_en", 96'({dma_en, m0_ready}), 96'(0));
      cyc(); cyc(); puc_rst = 1'b0; m1_en = 1'b0; per_read(REG_STALL1);
      #1;
      chk("t4_m0_regrant", 96'({dma_en, dma_addr}), 96'({1'b1, 15'h0033}));
      chk("t4_stall1_cleared", 96'(per_dout), 96'(0));
      cyc(); per_read(REG_CTRL);
      #1;
      chk("t4_ctrl_cleared", 96'(per_dout), 96'(0));
      cyc(); per_read(REG_STALL0);
      #1;
      chk("t4_stall0_cleared", 96'(per_dout), 96'(0));

      // round robin from a fresh reset: m0 first, then alternating
      cyc(); idle(); puc_rst = 1'b1;
      cyc(); puc_rst = 1'b0; per_write(REG_CTRL, 16'h0001);
      exp_q = '{15'h0111, 15'h0222, 15'h0111, 15'h0222};
      while (exp_q.size() > 0) begin
         logic [14:0] want;
         want = exp_q.pop_front();
         cyc(); idle();
         m0_en = 1'b1; m1_en = 1'b1; m0_addr = 15'h0111; m1_addr = 15'h0222; dma_ready = 1'b1;
         #1;
         chk("t5_rr_owner", 96'({dma_en, dma_addr}), 96'({1'b1, want}));
         cyc(); idle();
      end

      // randomized traffic against the model
      for (int i = 0; i < 3000; i++) begin
         cyc();
         puc_rst = ($urandom_range(0, 499) == 0);
         if ($urandom_range(0, 3) == 0) m0_en = ~m0_en;
         if ($urandom_range(0, 3) == 0) m1_en = ~m1_en;
         m0_addr = 15'($urandom); m1_addr = 15'($urandom);
         m0_din = 16'($urandom); m1_din = 16'($urandom);
         m0_we = $urandom_range(0, 1) ? 2'b00 : 2'($urandom_range(0, 3));
         m1_we = $urandom_range(0, 1) ? 2'b00 : 2'($urandom_range(0, 3));
         m0_priority = 1'($urandom_range(0, 1)); m1_priority = 1'($urandom_range(0, 1));
         dma_ready = ($urandom_range(0, 3) != 0);
         dma_dout = 16'($urandom); dma_resp = 1'($urandom_range(0, 1));
         per_en = ($urandom_range(0, 3) == 0);
         per_addr = $urandom_range(0, 3) != 0 ? REG_CTRL + 14'($urandom_range(0, 3)) : 14'($urandom);
         per_we = $urandom_range(0, 2) != 0 ? 2'b00 : 2'($urandom_range(1, 3));
         per_din = 16'($urandom);
      end

      // stall counter saturation and write-over-increment
      cyc(); idle(); puc_rst = 1'b0; per_write(REG_CTRL, 16'h0000);
      for (int i = 0; i < 70000; i++) begin
         cyc(); idle(); m0_en = 1'b1; dma_ready = 1'b0;
      end
      per_read(REG_STALL0);
      #1;
      chk("t6_stall0_saturated", 96'(per_dout), 96'(16'hFFFF));
      cyc(); idle(); m0_en = 1'b1; dma_ready = 1'b0; per_write(REG_STALL0, 16'h0000);
      cyc(); idle(); per_read(REG_STALL0);
      #1;
      chk("t6_stall0_write_wins", 96'(per_dout), 96'(0));

      cyc(); idle();
      repeat (3) cyc();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
